seg_scan_ctrl: RTL and testbench

Time-multiplexing controller for a 4-digit common-anode seven-segment display. It shares the single MC14495-style hex-to-segment decoder across four digits. Each digit slot drives the decoder's 4-bit hex input, its point input and its LE/blank input, and enables one anode. New display contents are accepted through a load strobe. They take effect only at a frame boundary, so a partially updated frame is never shown.

---
 rtl/seg_scan_ctrl_if.sv | 25 ++
 rtl/seg_scan_ctrl.sv | 95 +++++++++
 tb/tb_seg_scan_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Bundle between a display-contents producer and the segment scan controller.
// Carries the load strobe with its digit data and the decoder/anode drive outputs.
// The producer owns load/hexs/points/les; the controller owns everything else.
interface seg_scan_ctrl_if;
  logic        load;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  les;
  logic [3:0]  hex_out;
  logic        point_out;
  logic        le_out;
  logic [3:0]  AN;
  logic        frame_tick;
  logic        pending;

  modport master (
    output load, hexs, points, les,
    input  hex_out, point_out, le_out, AN, frame_tick, pending
  );

  modport slave (
    input  load, hexs, points, les,
    output hex_out, point_out, le_out, AN, frame_tick, pending
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Purpose: scans four 7-seg digits through one shared hex decoder, double-buffered display data.
// Latency: a load is shown from the next frame start (1 cycle min when on the commit edge, 4*SCAN_DIV max).
// Backpressure: none; load is always accepted, later loads overwrite the shadow until the frame boundary.
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 4
) (
  input logic          clk,
  input logic          rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      sh_hex;
  logic [3:0]       sh_pt;
  logic [3:0]       sh_le;
  logic [15:0]      ac_hex;
  logic [3:0]       ac_pt;
  logic [3:0]       ac_le;
  logic             pending_q;
  logic             frame_tick_q;

  logic slot_end;
  logic frame_end;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);

  // Slot timer and digit index: one digit per SCAN_DIV cycles, order 0,1,2,3.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow capture on load; shadow (or same-cycle load data) moves to the active set only at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_hex       <= '0;
      sh_pt        <= '0;
      sh_le        <= 4'b1111;
      ac_hex       <= '0;
      ac_pt        <= '0;
      ac_le        <= 4'b1111;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= frame_end;
      if (bus.load) begin
        sh_hex <= bus.hexs;
        sh_pt  <= bus.points;
        sh_le  <= bus.les;
      end
      if (frame_end) begin
        pending_q <= 1'b0;
        if (bus.load) begin
          ac_hex <= bus.hexs;
          ac_pt  <= bus.points;
          ac_le  <= bus.les;
        end else if (pending_q) begin
          ac_hex <= sh_hex;
          ac_pt  <= sh_pt;
          ac_le  <= sh_le;
        end
      end else if (bus.load) begin
        pending_q <= 1'b1;
      end
    end
  end

  // Decoder and anode drive, decoded from registers only; anodes dark for the first BLANK cycles of a slot.
  always_comb begin
    bus.hex_out    = ac_hex[{idx, 2'b00} +: 4];
    bus.point_out  = ac_pt[idx];
    bus.le_out     = ac_le[idx];
    bus.frame_tick = frame_tick_q;
    bus.pending    = pending_q;
    bus.AN         = 4'b1111;
    if (cnt >= BLANK_END) begin
      bus.AN = ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=8, BLANK=2.
// Every cycle's expected outputs are queued when the stimulus for that edge is applied and
// compared when the cycle is sampled; a few absolute values from the scenarios are checked too.
module tb_seg_scan_ctrl;

  localparam int SD = 8;
  localparam int BL = 2;
  localparam int FR = 4 * SD;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] hex;
    logic       pt;
    logic       le;
    logic       ft;
    logic       pend;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  obs_t obs;
  assign obs = {bus.AN, bus.hex_out, bus.point_out, bus.le_out, bus.frame_tick, bus.pending};

  obs_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   t     = 0;

  // Expected display state, tracked at the level of shadow/active contents
  logic [15:0] m_sh_hex, m_ac_hex;
  logic [3:0]  m_sh_pt, m_ac_pt, m_sh_le, m_ac_le;
  logic        m_pend;

  function automatic obs_t expect_at(int tt);
    obs_t e;
    int   slot;
    int   c;
    slot   = (tt / SD) % 4;
    c      = tt % SD;
    e.an   = (c < BL) ? 4'b1111 : ~(4'b0001 << slot);
    e.hex  = m_ac_hex[slot*4 +: 4];
    e.pt   = m_ac_pt[slot];
    e.le   = m_ac_le[slot];
    e.ft   = (tt != 0) && (tt % FR == 0);
    e.pend = m_pend;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, want);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    m_sh_hex = '0;
    m_ac_hex = '0;
    m_sh_pt  = '0;
    m_ac_pt  = '0;
    m_sh_le  = 4'b1111;
    m_ac_le  = 4'b1111;
    m_pend   = 1'b0;
  endtask

  task automatic tick(input logic r, input logic ld, input logic [15:0] h,
                      input logic [3:0] p, input logic [3:0] l);
    obs_t e;
    logic commit;
    @(negedge clk);
    chk("sb_depth", 16'(q.size()), 16'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("cycle", 16'(obs), 16'(e));
    end
    rst        = r;
    bus.load   = ld;
    bus.hexs   = h;
    bus.points = p;
    bus.les    = l;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      commit = (t % FR == FR - 1);
      if (ld) begin
        m_sh_hex = h;
        m_sh_pt  = p;
        m_sh_le  = l;
      end
      if (commit) begin
        if (ld || m_pend) begin
          m_ac_hex = m_sh_hex;
          m_ac_pt  = m_sh_pt;
          m_ac_le  = m_sh_le;
        end
        m_pend = 1'b0;
      end else if (ld) begin
        m_pend = 1'b1;
      end
      t++;
    end
    #1;
    q.push_back(expect_at(t));
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000);
  endtask

  task automatic run_to(input int tt);
    while (t < tt) idle();
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
    tick(1'b0, 1'b1, h, p, l);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000);
  endtask

  initial begin
    bus.load   = 1'b0;
    bus.hexs   = '0;
    bus.points = '0;
    bus.les    = '0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    q.push_back(expect_at(0));

    // Scenario 1: idle scan after reset
    chk("s1_rst_an", 16'(bus.AN), 16'hF);
    chk("s1_rst_le", 16'(bus.le_out), 16'd1);
    chk("s1_rst_ft", 16'(bus.frame_tick), 16'd0);
    run_to(2);
    chk("s1_an_d0", 16'(bus.AN), 16'hE);
    run_to(10);
    chk("s1_an_d1", 16'(bus.AN), 16'hD);
    run_to(26);
    chk("s1_an_d3", 16'(bus.AN), 16'h7);
    run_to(32);
    chk("s1_ft32", 16'(bus.frame_tick), 16'd1);
    run_to(33);
    chk("s1_ft33", 16'(bus.frame_tick), 16'd0);
    run_to(40);

    // Scenario 2: mid-frame load, committed at the frame boundary
    do_reset();
    run_to(5);
    do_load(16'h3A7F, 4'b0101, 4'b0000);
    chk("s2_pend6", 16'(bus.pending), 16'd1);
    run_to(31);
    chk("s2_old_le", 16'(bus.le_out), 16'd1);
    run_to(32);
    chk("s2_hex_d0", 16'(bus.hex_out), 16'hF);
    chk("s2_pt_d0", 16'(bus.point_out), 16'd1);
    chk("s2_pend32", 16'(bus.pending), 16'd0);
    run_to(40);
    chk("s2_hex_d1", 16'(bus.hex_out), 16'h7);
    run_to(48);
    chk("s2_hex_d2", 16'(bus.hex_out), 16'hA);
    run_to(56);
    chk("s2_hex_d3", 16'(bus.hex_out), 16'h3);
    chk("s2_pt_d3", 16'(bus.point_out), 16'd0);
    run_to(66);

    // Scenario 3: two loads before a commit, last one wins
    do_reset();
    run_to(10);
    do_load(16'h1111, 4'b0000, 4'b0000);
    run_to(20);
    do_load(16'h2222, 4'b0000, 4'b0000);
    run_to(32);
    chk("s3_hex32", 16'(bus.hex_out), 16'h2);
    run_to(66);

    // Scenario 4: load exactly on the commit edge
    do_reset();
    run_to(31);
    do_load(16'hBEEF, 4'b0000, 4'b0000);
    chk("s4_hex32", 16'(bus.hex_out), 16'hF);
    chk("s4_pend32", 16'(bus.pending), 16'd0);
    run_to(40);
    chk("s4_hex40", 16'(bus.hex_out), 16'hE);
    run_to(66);

    // Scenario 5: per-digit blanking
    do_reset();
    run_to(3);
    do_load(16'h00C0, 4'b0000, 4'b1011);
    run_to(40);
    chk("s5_le_d1", 16'(bus.le_out), 16'd1);
    chk("s5_hex_d1", 16'(bus.hex_out), 16'hC);
    run_to(48);
    chk("s5_le_d2", 16'(bus.le_out), 16'd0);
    run_to(66);

    // Scenario 6: reset mid-slot with pending data; a load alongside reset is ignored
    do_reset();
    run_to(5);
    do_load(16'h5A5A, 4'b1111, 4'b0000);
    run_to(19);
    chk("s6_pend19", 16'(bus.pending), 16'd1);
    tick(1'b1, 1'b1, 16'hFFFF, 4'b1111, 4'b0000);
    chk("s6_an", 16'(bus.AN), 16'hF);
    chk("s6_pend", 16'(bus.pending), 16'd0);
    chk("s6_le", 16'(bus.le_out), 16'd1);
    run_to(2);
    chk("s6_an_d0", 16'(bus.AN), 16'hE);
    run_to(32);
    chk("s6_hex32", 16'(bus.hex_out), 16'h0);
    chk("s6_le32", 16'(bus.le_out), 16'd1);
    run_to(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
